// File: rtl/demux8_reg_pkg.sv
// rtl/demux8_reg_pkg.sv - shared constants and helpers for the demux8_reg block
package demux8_reg_pkg;

  localparam int NUM_REGS      = 8;
  localparam int SEL_W         = 3;
  localparam int DEFAULT_WIDTH = 32;
  localparam int BYTES         = DEFAULT_WIDTH / 8;

  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VAL = 32'h0000_0000;

  // Ready/clear FSM encoding: READY accepts writes, DRAIN is the one dead
  // cycle after reset or clear.
  localparam logic [0:0] READY = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  // One-hot decode of a register index.
  function automatic logic [NUM_REGS-1:0] selOneHot(input logic [SEL_W-1:0] s);
    selOneHot = NUM_REGS'(1) << s;
  endfunction

endpackage

// File: rtl/demux8_reg_if.sv
// rtl/demux8_reg_if.sv - write-side request bus of the demux8_reg block
interface demux8_reg_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0]                    iData;
  logic [demux8_reg_pkg::SEL_W-1:0]    sel;
  logic                                iValid;
  logic [WIDTH/8-1:0]                  iByteEn;
  logic                                iClear;
  logic                                oReady;

  // Producer side drives the request, the register bank answers with oReady.
  modport master (
    output iData, sel, iValid, iByteEn, iClear,
    input  oReady
  );

  modport slave (
    input  iData, sel, iValid, iByteEn, iClear,
    output oReady
  );

endinterface

// File: rtl/demux8_reg_byte_merge.sv
// rtl/demux8_reg_byte_merge.sv - per-byte select of new versus old word
module demux8_reg_byte_merge #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   oldWord,
  input  logic [WIDTH-1:0]   newWord,
  input  logic [WIDTH/8-1:0] byteEn,
  output logic [WIDTH-1:0]   merged
);

  // Each enabled byte lane takes the new data, the rest keep the old word.
  for (genvar k = 0; k < WIDTH / 8; k++) begin : gLane
    assign merged[8*k +: 8] = byteEn[k] ? newWord[8*k +: 8] : oldWord[8*k +: 8];
  end

endmodule

// File: rtl/demux8_reg.sv
// rtl/demux8_reg.sv - 1-to-8 registered demultiplexer with byte enables
module demux8_reg
  import demux8_reg_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
  input  logic                 clk,
  input  logic                 rst,
  demux8_reg_if.slave          bus,
  output logic [WIDTH-1:0]     oData1,
  output logic [WIDTH-1:0]     oData2,
  output logic [WIDTH-1:0]     oData3,
  output logic [WIDTH-1:0]     oData4,
  output logic [WIDTH-1:0]     oData5,
  output logic [WIDTH-1:0]     oData6,
  output logic [WIDTH-1:0]     oData7,
  output logic [WIDTH-1:0]     oData8,
  output logic [NUM_REGS-1:0]  oUpdated,
  output logic [NUM_REGS-1:0]  oWritten,
  output logic [SEL_W-1:0]     oLastSel
);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [0:0]       state;
  logic             flush;
  logic             accept;
  logic [WIDTH-1:0] curWord;
  logic [WIDTH-1:0] mergedWord;

  // Reset and clear share one flush path; reset simply wins by also being OR'd in.
  assign flush  = rst || bus.iClear;
  assign accept = bus.iValid && (state == READY) && !bus.iClear;

  // oReady comes straight from the state register, so no input reaches it combinationally.
  assign bus.oReady = (state == READY);

  // A single merge unit serves whichever register sel points at.
  assign curWord = regs[bus.sel];

  demux8_reg_byte_merge #(
    .WIDTH (WIDTH)
  ) uMerge (
    .oldWord (curWord),
    .newWord (bus.iData),
    .byteEn  (bus.iByteEn),
    .merged  (mergedWord)
  );

  // Ready/clear FSM: any flush parks in DRAIN for one cycle, otherwise READY.
  always_ff @(posedge clk) begin
    if (flush) begin
      state <= DRAIN;
    end else begin
      state <= READY;
    end
  end

  // Register bank: flush loads RESET_VAL everywhere, an accepted write updates one entry.
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (accept) begin
      regs[bus.sel] <= mergedWord;
    end
  end

  // Status flags: one-cycle update pulse, sticky written mask and last index.
  always_ff @(posedge clk) begin
    if (flush) begin
      oUpdated <= '0;
      oWritten <= '0;
      oLastSel <= '0;
    end else begin
      oUpdated <= accept ? selOneHot(bus.sel) : '0;
      if (accept) begin
        oWritten <= oWritten | selOneHot(bus.sel);
        oLastSel <= bus.sel;
      end
    end
  end

  assign oData1 = regs[0];
  assign oData2 = regs[1];
  assign oData3 = regs[2];
  assign oData4 = regs[3];
  assign oData5 = regs[4];
  assign oData6 = regs[5];
  assign oData7 = regs[6];
  assign oData8 = regs[7];

endmodule

// File: tb/tb_demux8_reg.sv
// tb/tb_demux8_reg.sv - self-checking bench for demux8_reg
module tb_demux8_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] dOut [8];
  logic [7:0]  oUpdated;
  logic [7:0]  oWritten;
  logic [2:0]  oLastSel;

  demux8_reg_if #(.WIDTH(32)) bus();

  demux8_reg #(
    .WIDTH     (32),
    .RESET_VAL (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .oData1   (dOut[0]),
    .oData2   (dOut[1]),
    .oData3   (dOut[2]),
    .oData4   (dOut[3]),
    .oData5   (dOut[4]),
    .oData6   (dOut[5]),
    .oData7   (dOut[6]),
    .oData8   (dOut[7]),
    .oUpdated (oUpdated),
    .oWritten (oWritten),
    .oLastSel (oLastSel)
  );

  // Reference model state
  logic [31:0] mData [8];
  logic [7:0]  mUpd;
  logic [7:0]  mWr;
  logic [2:0]  mLast;
  logic        mReady;

  int testsRun    = 0;
  int testsFailed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the behavioural rules to the inputs present at this clock edge.
  task automatic modelEdge();
    if (rst || bus.iClear) begin
      for (int i = 0; i < 8; i++) mData[i] = 32'h0;
      mUpd   = 8'h00;
      mWr    = 8'h00;
      mLast  = 3'd0;
      mReady = 1'b0;
    end else begin
      mUpd = 8'h00;
      if (bus.iValid && mReady) begin
        for (int k = 0; k < 4; k++) begin
          if (bus.iByteEn[k]) mData[bus.sel][8*k +: 8] = bus.iData[8*k +: 8];
        end
        mUpd[bus.sel] = 1'b1;
        mWr[bus.sel]  = 1'b1;
        mLast         = bus.sel;
      end
      mReady = 1'b1;
    end
  endtask

  task automatic checkAll(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s.oData%0d", tag, i + 1), dOut[i], mData[i]);
    check({tag, ".oUpdated"}, 32'(oUpdated), 32'(mUpd));
    check({tag, ".oWritten"}, 32'(oWritten), 32'(mWr));
    check({tag, ".oLastSel"}, 32'(oLastSel), 32'(mLast));
    check({tag, ".oReady"},   32'(bus.oReady), 32'(mReady));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(tag);
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [3:0] be,
                       input logic [31:0] d, input logic clr);
    bus.iValid  = v;
    bus.sel     = s;
    bus.iByteEn = be;
    bus.iData   = d;
    bus.iClear  = clr;
  endtask

  initial begin
    logic [7:0] expOh;

    // Reset held two cycles with a live write request
    rst = 1'b1;
    drive(1'b1, 3'd3, 4'hF, 32'hCAFE_F00D, 1'b0);
    step("rst0");
    step("rst1");
    check("rst.ready", 32'(bus.oReady), 32'd0);
    check("rst.written", 32'(oWritten), 32'd0);

    rst = 1'b0;
    drive(1'b0, 3'd0, 4'hF, 32'h0, 1'b0);
    step("rstRel");
    check("rstRel.ready", 32'(bus.oReady), 32'd1);

    // Full-word fill, back to back
    for (int n = 0; n < 8; n++) begin
      drive(1'b1, 3'(n), 4'hF, 32'h1111_0000 + 32'(n), 1'b0);
      step("fill");
      expOh = 8'h01 << n;
      check($sformatf("fill.pulse%0d", n), 32'(oUpdated), 32'(expOh));
    end
    check("fill.written", 32'(oWritten), 32'hFF);
    check("fill.lastSel", 32'(oLastSel), 32'd7);
    for (int n = 0; n < 8; n++) check($sformatf("fill.data%0d", n + 1), dOut[n], 32'h1111_0000 + 32'(n));

    // Byte merge on register 3
    drive(1'b1, 3'd2, 4'hF, 32'hAABB_CCDD, 1'b0);
    step("merge0");
    drive(1'b1, 3'd2, 4'b0101, 32'h1122_3344, 1'b0);
    step("merge1");
    check("merge.oData3", dOut[2], 32'hAA22_CC44);
    check("merge.oData2", dOut[1], 32'h1111_0001);

    // Zero byte enable: counted access, no data change
    drive(1'b1, 3'd6, 4'h0, 32'h5555_5555, 1'b0);
    step("be0");
    check("be0.oData7", dOut[6], 32'h1111_0006);
    check("be0.pulse", 32'(oUpdated), 32'h40);

    // Clear with a simultaneous write
    drive(1'b1, 3'd5, 4'hF, 32'hDEAD_BEEF, 1'b1);
    step("clear");
    check("clear.oData6", dOut[5], 32'h0);
    check("clear.ready", 32'(bus.oReady), 32'd0);
    check("clear.written", 32'(oWritten), 32'd0);

    // Write held through the drain cycle
    drive(1'b1, 3'd4, 4'hF, 32'h0BAD_F00D, 1'b0);
    step("drain");
    check("drain.pulse", 32'(oUpdated), 32'd0);
    check("drain.ready", 32'(bus.oReady), 32'd1);
    step("drainAcc");
    check("drainAcc.pulse", 32'(oUpdated), 32'h10);
    check("drainAcc.oData5", dOut[4], 32'h0BAD_F00D);

    // Randomized traffic with occasional clear and reset
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            $urandom, $urandom_range(0, 15) == 0);
      step("rnd");
    end

    // Reset in the middle of a burst
    rst = 1'b0;
    drive(1'b0, 3'd0, 4'hF, 32'h0, 1'b0);
    step("midIdle");
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 3'(n + 1), 4'hF, $urandom, 1'b0);
      step("midBurst");
    end
    rst = 1'b1;
    drive(1'b1, 3'd6, 4'hF, 32'h7777_7777, 1'b0);
    step("midRst");
    for (int n = 0; n < 8; n++) check($sformatf("midRst.data%0d", n + 1), dOut[n], 32'h0);
    check("midRst.pulse", 32'(oUpdated), 32'd0);
    rst = 1'b0;
    step("midPost");
    check("midPost.pulse", 32'(oUpdated), 32'd0);
    check("midPost.ready", 32'(bus.oReady), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
